// File: rtl/saida_display_bcd.sv
// Output stage: converts the captured ALU result to signed decimal and drives
// four active-low 7-segment displays through a sequential double-dabble engine.
module saida_display_bcd #(
  parameter int MAG_W = 14
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        out_valid,
  input  logic [31:0] result_ULA,
  output logic [6:0]  Display1,
  output logic [6:0]  Display2,
  output logic [6:0]  Display3,
  output logic [6:0]  Display4,
  output logic        busy,
  output logic        overflow
);

  localparam int BCD_W = 16;
  localparam int SH_W  = BCD_W + MAG_W;
  localparam logic [3:0] CNT_LOAD = 4'(MAG_W);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state_r;
  logic [SH_W-1:0]   shiftReg_r;
  logic [3:0]        bitCnt_r;
  logic              sign_r;
  logic              ovf_r;
  logic [31:0]       pending_r;
  logic              pendValid_r;

  logic [31:0]       capSrc_s;
  logic [31:0]       capMag_s;
  logic              capOvf_s;
  logic [SH_W-1:0]   capLoad_s;
  logic [BCD_W-1:0]  bcdAdj_s;
  logic [SH_W-1:0]   shiftNext_s;
  logic [3:0]        dig0_s, dig1_s, dig2_s, dig3_s;
  logic [6:0]        disp1Next_s, disp2Next_s, disp3Next_s, disp4Next_s;

  function automatic logic [6:0] segOf(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  function automatic logic [BCD_W-1:0] addThree(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

  // Capture source: DONE without a live request restarts from the pending buffer
  always_comb begin
    capSrc_s = result_ULA;
    if ((state_r == DONE) && !out_valid) begin
      capSrc_s = pending_r;
    end else begin
      capSrc_s = result_ULA;
    end
    capMag_s  = capSrc_s[31] ? (32'd0 - capSrc_s) : capSrc_s;
    // Unsigned compare also flags -2^31, whose magnitude stays 0x80000000
    capOvf_s  = capSrc_s[31] ? (capMag_s > 32'd999) : (capMag_s > 32'd9999);
    capLoad_s = {{BCD_W{1'b0}}, capMag_s[MAG_W-1:0]};
  end

  // One double-dabble step: correct every BCD nibble, then shift left
  always_comb begin
    bcdAdj_s    = addThree(shiftReg_r[SH_W-1:MAG_W]);
    shiftNext_s = {bcdAdj_s[BCD_W-2:0], shiftReg_r[MAG_W-1:0], 1'b0};
  end

  assign dig0_s = shiftReg_r[MAG_W +: 4];
  assign dig1_s = shiftReg_r[MAG_W+4 +: 4];
  assign dig2_s = shiftReg_r[MAG_W+8 +: 4];
  assign dig3_s = shiftReg_r[MAG_W+12 +: 4];

  // Display patterns with sign, overflow and leading-zero blanking
  always_comb begin
    disp1Next_s = segOf(dig0_s);
    disp2Next_s = SEG_BLANK;
    disp3Next_s = SEG_BLANK;
    disp4Next_s = SEG_BLANK;
    if (ovf_r) begin
      disp1Next_s = SEG_BLANK;
      disp2Next_s = SEG_BLANK;
      disp3Next_s = SEG_BLANK;
      disp4Next_s = SEG_E;
    end else if (sign_r) begin
      disp4Next_s = SEG_MINUS;
      disp3Next_s = (dig2_s == 4'd0) ? SEG_BLANK : segOf(dig2_s);
      disp2Next_s = ((dig2_s == 4'd0) && (dig1_s == 4'd0)) ? SEG_BLANK : segOf(dig1_s);
    end else begin
      disp4Next_s = (dig3_s == 4'd0) ? SEG_BLANK : segOf(dig3_s);
      disp3Next_s = ((dig3_s == 4'd0) && (dig2_s == 4'd0)) ? SEG_BLANK : segOf(dig2_s);
      disp2Next_s = ((dig3_s == 4'd0) && (dig2_s == 4'd0) && (dig1_s == 4'd0))
                    ? SEG_BLANK : segOf(dig1_s);
    end
  end

  // Conversion FSM with pending buffer and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      shiftReg_r  <= {SH_W{1'b0}};
      bitCnt_r    <= 4'd0;
      sign_r      <= 1'b0;
      ovf_r       <= 1'b0;
      pending_r   <= 32'd0;
      pendValid_r <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      Display1    <= SEG_ZERO;
      Display2    <= SEG_BLANK;
      Display3    <= SEG_BLANK;
      Display4    <= SEG_BLANK;
    end else begin
      case (state_r)
        IDLE: begin
          if (out_valid) begin
            shiftReg_r <= capLoad_s;
            sign_r     <= capSrc_s[31];
            ovf_r      <= capOvf_s;
            bitCnt_r   <= CNT_LOAD;
            state_r    <= CONVERT;
            busy       <= 1'b1;
          end else begin
            busy       <= 1'b0;
          end
        end
        CONVERT: begin
          shiftReg_r <= shiftNext_s;
          bitCnt_r   <= bitCnt_r - 4'd1;
          if (bitCnt_r == 4'd1) begin
            state_r <= DONE;
          end
          if (out_valid) begin
            pending_r   <= result_ULA;
            pendValid_r <= 1'b1;
          end
        end
        DONE: begin
          Display1 <= disp1Next_s;
          Display2 <= disp2Next_s;
          Display3 <= disp3Next_s;
          Display4 <= disp4Next_s;
          overflow <= ovf_r;
          // A live request wins over, and discards, the pending value
          if (out_valid || pendValid_r) begin
            shiftReg_r  <= capLoad_s;
            sign_r      <= capSrc_s[31];
            ovf_r       <= capOvf_s;
            bitCnt_r    <= CNT_LOAD;
            pendValid_r <= 1'b0;
            state_r     <= CONVERT;
            busy        <= 1'b1;
          end else begin
            state_r     <= IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          pendValid_r <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saida_display_bcd.sv
// Directed bench for saida_display_bcd: hand-computed segment patterns,
// latency, back-to-back pending behaviour and asynchronous reset.
module tb_saida_display_bcd;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MN = 7'b0111111;
  localparam logic [6:0] EE = 7'b0000110;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        out_valid;
  logic [31:0] result_ULA;
  logic [6:0]  Display1, Display2, Display3, Display4;
  logic        busy;
  logic        overflow;

  int checkCount = 0;
  int errorCount = 0;

  saida_display_bcd #(.MAG_W(14)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .out_valid  (out_valid),
    .result_ULA (result_ULA),
    .Display1   (Display1),
    .Display2   (Display2),
    .Display3   (Display3),
    .Display4   (Display4),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, return at the following falling edge
  task automatic drive(input logic v, input logic [31:0] d);
    out_valid  = v;
    result_ULA = d;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  function automatic logic [31:0] pack(input logic [6:0] d4, input logic [6:0] d3,
                                       input logic [6:0] d2, input logic [6:0] d1);
    return {4'd0, d4, d3, d2, d1};
  endfunction

  task automatic convert(input string tag, input logic [31:0] value,
                         input logic [31:0] expDisp, input logic expOvf);
    drive(1'b1, value);
    checkVal({tag, "_busy"}, {31'd0, busy}, 32'd1);
    idle(15);
    checkVal({tag, "_disp"}, {4'd0, Display4, Display3, Display2, Display1}, expDisp);
    checkVal({tag, "_ovf"}, {31'd0, overflow}, {31'd0, expOvf});
    checkVal({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    out_valid  = 1'b0;
    result_ULA = 32'd0;
    repeat (2) @(negedge clock);
    checkVal("rst_disp", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, BL, S0));
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Latency: displays unchanged after edge k+14, updated after k+15
    drive(1'b1, 32'd1234);
    checkVal("lat_busy", {31'd0, busy}, 32'd1);
    idle(14);
    checkVal("lat_old", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, BL, S0));
    checkVal("lat_busy14", {31'd0, busy}, 32'd1);
    idle(1);
    checkVal("p1234", {4'd0, Display4, Display3, Display2, Display1}, pack(S1, S2, S3, S4));
    checkVal("p1234_busy", {31'd0, busy}, 32'd0);

    convert("p7", 32'd7, pack(BL, BL, BL, S7), 1'b0);
    convert("p0", 32'd0, pack(BL, BL, BL, S0), 1'b0);
    convert("p105", 32'd105, pack(BL, S1, S0, S5), 1'b0);
    convert("n45", -32'sd45, pack(MN, BL, S4, S5), 1'b0);
    convert("n7", -32'sd7, pack(MN, BL, BL, S7), 1'b0);
    convert("n999", -32'sd999, pack(MN, S9, S9, S9), 1'b0);
    convert("o10000", 32'd10000, pack(EE, BL, BL, BL), 1'b1);
    convert("p9999", 32'd9999, pack(S9, S9, S9, S9), 1'b0);
    convert("on1000", -32'sd1000, pack(EE, BL, BL, BL), 1'b1);
    convert("omin", 32'h8000_0000, pack(EE, BL, BL, BL), 1'b1);
    convert("p9999b", 32'd9999, pack(S9, S9, S9, S9), 1'b0);
    idle(3);

    // Back-to-back: 11 at 0, 22 at 3, 33 at 5; 22 is overwritten
    for (int i = 0; i <= 30; i++) begin
      if (i == 0)      drive(1'b1, 32'd11);
      else if (i == 3) drive(1'b1, 32'd22);
      else if (i == 5) drive(1'b1, 32'd33);
      else             drive(1'b0, $urandom);
      if (i < 30) checkVal($sformatf("b2b_busy%0d", i), {31'd0, busy}, 32'd1);
      if (i == 14) checkVal("b2b_pre", {4'd0, Display4, Display3, Display2, Display1}, pack(S9, S9, S9, S9));
      if (i == 15) checkVal("b2b_11", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, S1, S1));
      if (i == 29) checkVal("b2b_hold", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, S1, S1));
      if (i == 30) begin
        checkVal("b2b_33", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, S3, S3));
        checkVal("b2b_end", {31'd0, busy}, 32'd0);
      end
    end
    idle(3);

    // DONE collision: 44 pending, 55 arrives in the DONE cycle
    for (int i = 0; i <= 30; i++) begin
      if (i == 0)       drive(1'b1, 32'd66);
      else if (i == 5)  drive(1'b1, 32'd44);
      else if (i == 15) drive(1'b1, 32'd55);
      else              drive(1'b0, $urandom);
      if (i == 15) checkVal("col_66", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, 7'b0000010, 7'b0000010));
      if (i == 30) checkVal("col_55", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, S5, S5));
    end
    idle(16);
    checkVal("col_no44", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, S5, S5));
    checkVal("col_busy", {31'd0, busy}, 32'd0);

    // Reset mid-conversion with a pending value queued
    drive(1'b1, 32'd8888);
    idle(3);
    drive(1'b1, 32'd77);
    idle(2);
    reset_n = 1'b0;
    #1;
    checkVal("arst_disp", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, BL, S0));
    checkVal("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(20);
    checkVal("arst_drop", {4'd0, Display4, Display3, Display2, Display1}, pack(BL, BL, BL, S0));
    checkVal("arst_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
